float_to_fixed: RTL and testbench
=================================

Name: float_to_fixed

Overview:
- Serial converter from the team's 16-bit float format (1 sign, 5 exponent bias 15, 10 mantissa, hidden 1) to a signed two's-complement fixed-point value.
- It is the decode counterpart of the float adder datapath. It sits at the output of the convolution accumulators, where FP16 partial sums are turned into integer/fixed results for downstream quantisation.
- Alignment uses one shift per clock under a small FSM, with a start/busy/done handshake.

Parameters:
- OUT_W, 16: output width in bits, legal range 12..32.
- FRAC_BITS, 0: number of fractional bits in the output, legal range 0..16. The output equals value * 2^FRAC_BITS, truncated toward zero.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request conversion of float_in; sampled only in IDLE.
- float_in  in  16  FP16 operand; sampled on the accepting edge only.
- busy  out  1  high whenever state != IDLE (decoded from the state register).
- done  out  1  one-cycle pulse; int_out/overflow valid from this cycle on.
- int_out  out  OUT_W  signed fixed-point result; held until the next done.
- overflow  out  1  result saturated; held with int_out.

Behaviour:
- Reset: state=IDLE, done=0, int_out=0, overflow=0, internal registers cleared. Reset takes effect immediately, including mid-conversion, and discards that conversion.
- Format rules:
  - Zero iff float_in[14:0]==0 (either sign).
  - Every other encoding, including exponent 0 or 31, is treated as normal: sig = {1, mantissa} (11 bits).
  - No inf/NaN/subnormal handling.
- Shift count: k = exp - 25 + FRAC_BITS (signed, 7 bits).
  - k>0: left shift k.
  - k<0: right shift -k, truncating.
- FSM states: IDLE, SHIFT, OUT.
- IDLE, start=1 (edge E0):
  - Latch sign.
  - MAG (OUT_W-bit unsigned) = zero-extended sig.
  - CNT = |k|, DIR = sign of k.
  - If zero operand: MAG=0 and next state is OUT.
  - Else if k==0: next state is OUT.
  - Else: next state is SHIFT.
- SHIFT, each edge:
  - Right: MAG>>=1, CNT-=1. Go to OUT when CNT reaches 0 or the new MAG is 0 (early exit).
  - Left: if MAG[OUT_W-1]==1 before shifting, set internal ovf and go to OUT with no shift. Else MAG<<=1, CNT-=1, and go to OUT when CNT reaches 0.
- OUT, one edge, then return to IDLE:
  - Positive: if ovf or MAG > 2^(OUT_W-1)-1, int_out = 2^(OUT_W-1)-1 and overflow=1. Else int_out=MAG and overflow=0.
  - Negative: if ovf or MAG > 2^(OUT_W-1), int_out = -2^(OUT_W-1) and overflow=1. Else int_out=-MAG and overflow=0. -2^(OUT_W-1) is exactly representable and is not an overflow.
  - done<=1. done is cleared on the following edge.
- Latency: with N SHIFT edges, done is high in the cycle after edge E(N+1), i.e. N+1 edges after acceptance.
  - N = 0 for zero operand or k==0.
  - Right shifts are bounded by min(|k|, 12).
  - Left shifts are bounded by min(k, OUT_W).
- Handshake:
  - start while busy is ignored; the operand is not queued.
  - start in the same cycle done is high is accepted, since the state is IDLE.
  - float_in may change freely after E0.
- Outputs change only on the OUT edge or on reset.

Test Plan:
- OUT_W=16, FRAC_BITS=0, float_in=0x3C00 (1.0), start pulse -> 10 SHIFT edges; done pulses once, 11 edges after acceptance; int_out=0x0001, overflow=0, busy low in the done cycle.
- float_in=0xC500 (-5.0) -> int_out=0xFFFB, overflow=0, 8 shifts. float_in=0x3800 (0.5) -> int_out=0x0000 via right shift to zero. float_in=0x8000 -> int_out=0, done 1 edge after acceptance.
- Saturation:
  - 0x7800 (32768) -> int_out=0x7FFF, overflow=1.
  - 0xF800 (-32768) -> int_out=0x8000, overflow=0.
  - 0x7BFF (65504) -> int_out=0x7FFF, overflow=1.
  - 0x7C00 -> early-stop overflow: 5 shifts, then 0x7FFF, overflow=1.
- FRAC_BITS=8: float_in=0x3E00 (1.5) -> int_out=0x0180 after 2 right shifts. float_in=0x4900 (10.0) -> int_out=0x0A00.
- Handshake: start held high through a conversion of 0x3C00 while float_in changes -> exactly one result (1) per acceptance. A new start on the done cycle with 0xC500 -> accepted and completes with 0xFFFB.
- Reset: assert rst during SHIFT of 0x3C00 -> busy, done, int_out and overflow go to 0 without waiting for a clock edge. After release, the next start converts normally.

Source files
------------

// File: rtl/float_to_fixed.sv
// Serial FP16 (1/5/10, bias 15) to signed fixed-point converter.
// Alignment shifts one bit per clock; start/busy/done handshake.
module float_to_fixed #(
   parameter int unsigned OUT_W     = 16,
   parameter int unsigned FRAC_BITS = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [15:0]      float_in,
   output logic             busy,
   output logic             done,
   output logic [OUT_W-1:0] int_out,
   output logic             overflow
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SHIFT = 2'd1;
   localparam logic [1:0] OUT   = 2'd2;

   localparam logic [OUT_W-1:0] POS_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] NEG_MAX = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] ONE     = {{(OUT_W-1){1'b0}}, 1'b1};
   localparam logic signed [6:0] FRAC_K = 7'(FRAC_BITS);

   logic [1:0]       state_q, state_d;
   logic             sign_q, sign_d;
   logic             dir_q, dir_d;     // 1: left shift
   logic             ovf_q, ovf_d;
   logic [5:0]       cnt_q, cnt_d;
   logic [OUT_W-1:0] mag_q, mag_d;
   logic             done_d;
   logic [OUT_W-1:0] int_out_d;
   logic             overflow_d;

   logic [4:0]        exp_in;
   logic [10:0]       sig_in;
   logic              zero_in;
   logic signed [6:0] k;
   logic [5:0]        k_mag;
   logic [OUT_W-1:0]  mag_shr;
   logic [OUT_W-1:0]  mag_neg;

   assign exp_in  = float_in[14:10];
   assign sig_in  = {1'b1, float_in[9:0]};
   assign zero_in = (float_in[14:0] == 15'd0);
   assign k       = $signed({2'b00, exp_in}) - 7'sd25 + FRAC_K;
   assign k_mag   = k[6] ? 6'(-k) : 6'(k);
   assign mag_shr = mag_q >> 1;
   assign mag_neg = (~mag_q) + ONE;

   assign busy = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      sign_d     = sign_q;
      dir_d      = dir_q;
      ovf_d      = ovf_q;
      cnt_d      = cnt_q;
      mag_d      = mag_q;
      done_d     = 1'b0;
      int_out_d  = int_out;
      overflow_d = overflow;
      case (state_q)
         IDLE: begin
            if (start) begin
               sign_d = float_in[15];
               mag_d  = zero_in ? '0 : {{(OUT_W-11){1'b0}}, sig_in};
               cnt_d  = k_mag;
               dir_d  = ~k[6];
               ovf_d  = 1'b0;
               if (zero_in || (k == 7'sd0)) begin
                  state_d = OUT;
               end else begin
                  state_d = SHIFT;
               end
            end
         end
         SHIFT: begin
            if (dir_q) begin
               // A set MSB means any further left shift loses magnitude.
               if (mag_q[OUT_W-1]) begin
                  ovf_d   = 1'b1;
                  state_d = OUT;
               end else begin
                  mag_d = mag_q << 1;
                  cnt_d = cnt_q - 6'd1;
                  if (cnt_q == 6'd1) state_d = OUT;
               end
            end else begin
               mag_d = mag_shr;
               cnt_d = cnt_q - 6'd1;
               if ((cnt_q == 6'd1) || (mag_shr == '0)) state_d = OUT;
            end
         end
         OUT: begin
            if (!sign_q) begin
               if (ovf_q || (mag_q > POS_MAX)) begin
                  int_out_d  = POS_MAX;
                  overflow_d = 1'b1;
               end else begin
                  int_out_d  = mag_q;
                  overflow_d = 1'b0;
               end
            end else begin
               // -2^(OUT_W-1) is representable, so compare against NEG_MAX inclusively.
               if (ovf_q || (mag_q > NEG_MAX)) begin
                  int_out_d  = NEG_MAX;
                  overflow_d = 1'b1;
               end else begin
                  int_out_d  = mag_neg;
                  overflow_d = 1'b0;
               end
            end
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         sign_q   <= 1'b0;
         dir_q    <= 1'b0;
         ovf_q    <= 1'b0;
         cnt_q    <= '0;
         mag_q    <= '0;
         done     <= 1'b0;
         int_out  <= '0;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         sign_q   <= sign_d;
         dir_q    <= dir_d;
         ovf_q    <= ovf_d;
         cnt_q    <= cnt_d;
         mag_q    <= mag_d;
         done     <= done_d;
         int_out  <= int_out_d;
         overflow <= overflow_d;
      end
   end

endmodule

// File: tb/tb_float_to_fixed.sv
// Self-checking bench for float_to_fixed: directed cases plus random operands
// checked against an arithmetic reference model (two instances, FRAC_BITS 0 and 8).
module tb_float_to_fixed;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start0, start1;
   logic [15:0]   fin0, fin1;
   logic          busy0, busy1, done0, done1, ovf0, ovf1;
   logic [W-1:0]  iout0, iout1;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   float_to_fixed #(.OUT_W(W), .FRAC_BITS(0)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .float_in(fin0),
      .busy(busy0), .done(done0), .int_out(iout0), .overflow(ovf0)
   );

   float_to_fixed #(.OUT_W(W), .FRAC_BITS(8)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .float_in(fin1),
      .busy(busy1), .done(done1), .int_out(iout1), .overflow(ovf1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: value*2^frac truncated toward zero, saturated; plus edge count to done.
   function automatic void model(input logic [15:0] f, input int frac,
                                 output logic [15:0] res, output logic ov, output int edges);
      int     e, k;
      longint mag, val;
      e = int'(f[14:10]);
      k = e - 25 + frac;
      if (f[14:0] == 15'd0) begin
         res = 16'h0; ov = 1'b0; edges = 1;
         return;
      end
      mag = longint'({1'b1, f[9:0]});
      if (k >= 0) mag = mag << k;
      else        mag = mag >> (-k);
      val = f[15] ? -mag : mag;
      ov  = 1'b0;
      if (val > 32767)       begin val = 32767;  ov = 1'b1; end
      else if (val < -32768) begin val = -32768; ov = 1'b1; end
      res = val[15:0];
      if (k == 0)      edges = 1;
      else if (k < 0)  edges = ((-k < 11) ? -k : 11) + 1;
      else             edges = ((k <= W - 11) ? k : W - 10) + 1;
   endfunction

   task automatic wait_done(input int sel, input logic [W-1:0] prev, output int n);
      logic got;
      got = 1'b0;
      n   = 0;
      while (!got && n < 100) begin
         @(posedge clk); #1;
         n++;
         if ((sel != 0) ? done1 : done0) got = 1'b1;
         else chk("hold int_out", (sel != 0) ? iout1 : iout0, prev);
      end
      if (!got) chk("done timeout", (sel != 0) ? done1 : done0, 1);
   endtask

   task automatic do_conv(input int sel, input logic [15:0] f, input string tag);
      logic [15:0]  er;
      logic         eo;
      int           en, n;
      logic [W-1:0] prev;
      model(f, (sel != 0) ? 8 : 0, er, eo, en);
      @(negedge clk);
      prev = (sel != 0) ? iout1 : iout0;
      if (sel != 0) begin start1 = 1'b1; fin1 = f; end
      else          begin start0 = 1'b1; fin0 = f; end
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      fin0   = 16'($urandom);
      fin1   = 16'($urandom);
      chk({tag, " busy"}, (sel != 0) ? busy1 : busy0, 1);
      wait_done(sel, prev, n);
      chk({tag, " latency"},  n, en);
      chk({tag, " int_out"},  (sel != 0) ? iout1 : iout0, er);
      chk({tag, " overflow"}, (sel != 0) ? ovf1 : ovf0, eo);
      chk({tag, " busy@done"}, (sel != 0) ? busy1 : busy0, 0);
      @(posedge clk); #1;
      chk({tag, " done pulse"}, (sel != 0) ? done1 : done0, 0);
   endtask

   initial begin
      int          n;
      logic [15:0] f;
      rst    = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      fin0   = 16'h0;
      fin1   = 16'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy",     busy0, 0);
      chk("reset done",     done0, 0);
      chk("reset int_out",  iout0, 0);
      chk("reset overflow", ovf0,  0);
      chk("reset int_out1", iout1, 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed, FRAC_BITS=0
      do_conv(0, 16'h3C00, "1.0");
      chk("1.0 explicit", iout0, 16'h0001);
      do_conv(0, 16'hC500, "-5.0");
      chk("-5.0 explicit", iout0, 16'hFFFB);
      do_conv(0, 16'h3800, "0.5");
      do_conv(0, 16'h8000, "-0");
      do_conv(0, 16'h7800, "32768");
      chk("32768 explicit", iout0, 16'h7FFF);
      do_conv(0, 16'hF800, "-32768");
      chk("-32768 explicit", iout0, 16'h8000);
      do_conv(0, 16'h7BFF, "65504");
      do_conv(0, 16'h7C00, "exp31");
      chk("exp31 ovf explicit", ovf0, 1);

      // Asynchronous reset mid-conversion (outputs currently 0x7FFF / ovf=1)
      @(negedge clk);
      start0 = 1'b1;
      fin0   = 16'h3C00;
      @(posedge clk); #1;
      start0 = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("async rst busy",     busy0, 0);
      chk("async rst done",     done0, 0);
      chk("async rst int_out",  iout0, 0);
      chk("async rst overflow", ovf0,  0);
      @(negedge clk);
      rst = 1'b0;
      do_conv(0, 16'h3C00, "post-reset 1.0");

      // Directed, FRAC_BITS=8
      do_conv(1, 16'h3E00, "f8 1.5");
      chk("f8 1.5 explicit", iout1, 16'h0180);
      do_conv(1, 16'h4900, "f8 10.0");
      chk("f8 10.0 explicit", iout1, 16'h0A00);

      // start held high through a conversion, then back-to-back accept on done
      @(negedge clk);
      start0 = 1'b1;
      fin0   = 16'h3C00;
      @(posedge clk); #1;
      n = 0;
      while (!done0 && n < 100) begin
         fin0 = 16'($urandom);
         @(posedge clk); #1;
         n++;
      end
      chk("held start latency", n, 11);
      chk("held start int_out", iout0, 16'h0001);
      chk("held start overflow", ovf0, 0);
      chk("held start busy@done", busy0, 0);
      fin0 = 16'hC500;
      @(posedge clk); #1;
      start0 = 1'b0;
      fin0   = 16'($urandom);
      chk("b2b busy", busy0, 1);
      chk("b2b done cleared", done0, 0);
      wait_done(0, 16'h0001, n);
      chk("b2b latency", n, 9);
      chk("b2b int_out", iout0, 16'hFFFB);
      chk("b2b overflow", ovf0, 0);

      // Random operands, biased half the time toward interesting exponents
      for (int i = 0; i < 40; i++) begin
         f = 16'($urandom);
         if (i[0]) f[14:10] = 5'(9 + $urandom_range(0, 22));
         do_conv(0, f, "rand f0");
      end
      for (int i = 0; i < 30; i++) begin
         f = 16'($urandom);
         if (i[0]) f[14:10] = 5'(4 + $urandom_range(0, 27));
         do_conv(1, f, "rand f8");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
